// File: rtl/softmax_max_sub_if.sv
// Score-load and exponent-handshake signals of the softmax max-subtract stage.
// master = softmax_max_sub, slave = upstream score source plus exponent FSM.
interface softmax_max_sub_if #(
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [31:0]   exp_in;
  logic          exp_start;
  logic          exp_done;
  logic [AW-1:0] exp_idx;
  logic [31:0]   max_out;
  logic          busy;
  logic          frame_done;

  modport master (
    input  in_valid, in_data, exp_done,
    output in_ready, exp_in, exp_start, exp_idx, max_out, busy, frame_done
  );

  modport slave (
    output in_valid, in_data, exp_done,
    input  in_ready, exp_in, exp_start, exp_idx, max_out, busy, frame_done
  );
endinterface

// File: rtl/softmax_max_sub.sv
// Buffers a frame of N FP32 scores while tracking their max, then issues each
// score-minus-max to the exponent FSM one element at a time.
module softmax_max_sub #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic                clk,
  input  logic                rst,
  softmax_max_sub_if.master   sif
);
  localparam int DATA_W = 32;

  localparam logic [2:0] LOAD  = 3'd0;
  localparam logic [2:0] SUB   = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]        state;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     exp_idx_r;
  logic [DATA_W-1:0] buf_r [N];
  logic [DATA_W-1:0] max_r;
  logic [DATA_W-1:0] exp_in_r;
  logic [DATA_W-1:0] diff;
  logic              exp_start_r;
  logic              frame_done_r;

  // Zero-exponent values (denormals, +/-0) collapse to +0 before comparing.
  function automatic logic fp_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] za, zb;
    za = (a[30:23] == 8'd0) ? '0 : a;
    zb = (b[30:23] == 8'd0) ? '0 : b;
    if (za[31] != zb[31]) return zb[31];
    if (za[31]) return za[30:0] < zb[30:0];
    return za[30:0] > zb[30:0];
  endfunction

  // Round-to-nearest-even on a 27-bit mantissa {hidden, frac[22:0], G, R, S}.
  function automatic logic [DATA_W-1:0] fp_round(input logic sign,
                                                 input logic signed [9:0] exp_v,
                                                 input logic [26:0] mant);
    logic [24:0]       r;
    logic signed [9:0] e;
    logic              up;
    up = mant[2] & (mant[1] | mant[0] | mant[3]);
    r  = {1'b0, mant[26:3]} + 25'(up);
    e  = exp_v;
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'sd1;
    end
    if (e <= 10'sd0) return '0;
    return {sign, e[7:0], r[22:0]};
  endfunction

  function automatic logic [DATA_W-1:0] fp_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] x, y;
    logic [26:0]       mx, my;
    logic [27:0]       sum;
    logic signed [9:0] ex;
    logic [7:0]        d;
    logic              sticky;
    logic              found;
    int                lz;
    if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? '0 : b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    mx     = {1'b1, x[22:0], 3'b000};
    my     = {1'b1, y[22:0], 3'b000};
    d      = x[30:23] - y[30:23];
    ex     = $signed({2'b00, x[30:23]});
    sticky = 1'b0;
    if (d >= 8'd27) begin
      my = 27'd1;
    end else if (d != 8'd0) begin
      for (int i = 0; i < 27; i++)
        if (i < int'(d) && my[i]) sticky = 1'b1;
      my = (my >> d) | {26'd0, sticky};
    end
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        ex  = ex + 10'sd1;
      end
    end else begin
      sum = {1'b0, mx} - {1'b0, my};
      if (sum == 28'd0) return '0;
      lz    = 0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found && !sum[i]) lz++;
        else found = 1'b1;
      end
      sum = sum << lz;
      ex  = ex - $signed(10'(lz));
    end
    return fp_round(x[31], ex, sum[26:0]);
  endfunction

  assign diff = fp_add(buf_r[exp_idx_r], {~max_r[31], max_r[30:0]});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      wr_idx       <= '0;
      exp_idx_r    <= '0;
      max_r        <= '0;
      exp_in_r     <= '0;
      exp_start_r  <= 1'b0;
      frame_done_r <= 1'b0;
      for (int i = 0; i < N; i++) buf_r[i] <= '0;
    end else begin
      exp_start_r  <= 1'b0;
      frame_done_r <= 1'b0;
      case (state)
        LOAD: if (sif.in_valid) begin
          buf_r[wr_idx] <= sif.in_data;
          if (wr_idx == '0 || fp_gt(sif.in_data, max_r)) max_r <= sif.in_data;
          wr_idx <= wr_idx + AW'(1);
          if (wr_idx == AW'(N-1)) begin
            exp_idx_r <= '0;
            state     <= SUB;
          end
        end
        // SUB -> ISSUE: difference registered, start pulse raised for one cycle.
        SUB: begin
          exp_in_r    <= (diff[30:23] == 8'd0) ? '0 : diff;
          exp_start_r <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (sif.exp_done) begin
          if (exp_idx_r == AW'(N-1)) begin
            frame_done_r <= 1'b1;
            state        <= DONE;
          end else begin
            exp_idx_r <= exp_idx_r + AW'(1);
            state     <= SUB;
          end
        end
        DONE: begin
          wr_idx    <= '0;
          exp_idx_r <= '0;
          state     <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign sif.in_ready   = (state == LOAD);
  assign sif.busy       = (state != LOAD);
  assign sif.exp_in     = exp_in_r;
  assign sif.exp_start  = exp_start_r;
  assign sif.exp_idx    = exp_idx_r;
  assign sif.max_out    = max_r;
  assign sif.frame_done = frame_done_r;
endmodule

// File: tb/tb_softmax_max_sub.sv
// Directed bench for softmax_max_sub (N=4): table of frames with hand-computed
// differences, plus stall, spurious-done, back-to-back and mid-frame reset runs.
module tb_softmax_max_sub;
  logic clk;
  logic rst;
  logic spur_done;
  logic model_done;

  softmax_max_sub_if #(.AW(2)) sif ();

  softmax_max_sub #(.N(4), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  assign sif.exp_done = model_done | spur_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][31:0] din;
    logic [31:0]      mx;
    logic [3:0][31:0] dout;
  } vec_t;

  vec_t tbl [6];

  int total = 0;
  int bad   = 0;

  // Monitor state (written only by the monitor process)
  int cyc = 0, acc_cnt = 0, st_cyc_cnt = 0, fd_cnt = 0, gap_err = 0;
  int last_acc_cyc = 0, first_start_cyc = 0, last_done_cyc = 0, fd_cyc = 0;
  bit seen_start = 1'b0;

  // Exponent-FSM model state (written only by the model process)
  int          lat_cur = 1;
  int          nstart = 0, ord_err = 0, stab_err = 0;
  logic [1:0]  exp_next = 2'd0;
  logic [31:0] cap_in [4];
  logic [31:0] m_val;
  logic [1:0]  m_idx;
  bit          m_abort;

  // Snapshots and knobs (written only by the main process)
  int lat = 1;
  int acc0, st0, sc0, fd0, gap0, ord0, stab0;

  function automatic vec_t mk(input logic [31:0] a0, a1, a2, a3, mx,
                              input logic [31:0] d0, d1, d2, d3);
    vec_t v;
    v.din[0] = a0; v.din[1] = a1; v.din[2] = a2; v.din[3] = a3;
    v.mx = mx;
    v.dout[0] = d0; v.dout[1] = d1; v.dout[2] = d2; v.dout[3] = d3;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (sif.in_valid && sif.in_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (model_done && sif.busy) last_done_cyc = cyc;
      if (sif.exp_start) begin
        st_cyc_cnt++;
        if (!seen_start) first_start_cyc = cyc;
        else if (cyc - last_done_cyc != 2) gap_err++;
        seen_start = 1'b1;
      end
      if (sif.frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
        seen_start = 1'b0;
      end
      if (rst) seen_start = 1'b0;
    end
  end

  // Exponent FSM model: answers each start after lat cycles, checks WAIT stability
  initial begin
    model_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_next = 2'd0;
      end else if (sif.exp_start) begin
        nstart++;
        lat_cur = lat;
        m_val = sif.exp_in;
        m_idx = sif.exp_idx;
        cap_in[m_idx] = m_val;
        if (m_idx != exp_next) ord_err++;
        exp_next = m_idx + 2'd1;
        m_abort = 1'b0;
        for (int c = 0; c < lat_cur && !m_abort; c++) begin
          @(posedge clk); #1;
          if (rst) m_abort = 1'b1;
          else if (sif.exp_start || sif.in_ready || !sif.busy ||
                   sif.exp_in != m_val || sif.exp_idx != m_idx) stab_err++;
        end
        if (!m_abort) begin
          model_done = 1'b1;
          @(posedge clk); #1;
          model_done = 1'b0;
        end else begin
          exp_next = 2'd0;
        end
      end
    end
  end

  task automatic snap();
    acc0 = acc_cnt; st0 = nstart; sc0 = st_cyc_cnt; fd0 = fd_cnt;
    gap0 = gap_err; ord0 = ord_err; stab0 = stab_err;
  endtask

  task automatic send(input logic [31:0] d);
    int t = 0;
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    @(negedge clk);
    while (!sif.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", 32'(sif.in_ready), 1);
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int v, input int first, input int spur_at);
    for (int i = first; i < 4; i++) begin
      if (i == spur_at) begin
        spur_done = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0;
        @(negedge clk);
        check("spur_load_busy", 32'(sif.busy), 0);
        check("spur_load_ready", 32'(sif.in_ready), 1);
        @(posedge clk); #1;
      end
      send(tbl[v].din[i]);
    end
  endtask

  task automatic wait_frame();
    int t = 0;
    @(negedge clk);
    while (!sif.frame_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("frame_done_seen", 32'(sif.frame_done), 1);
    check("ready_in_done", 32'(sif.in_ready), 0);
    @(negedge clk);
    check("ready_back", 32'(sif.in_ready), 1);
  endtask

  task automatic check_frame(input int v, input int nacc, input int lac, input bit chk_max);
    if (chk_max) check($sformatf("max_out[v%0d]", v), sif.max_out, tbl[v].mx);
    for (int i = 0; i < 4; i++)
      check($sformatf("exp_in[v%0d][%0d]", v, i), cap_in[i], tbl[v].dout[i]);
    check("starts", nstart - st0, 4);
    check("start_width", st_cyc_cnt - sc0, 4);
    check("frame_done_cnt", fd_cnt - fd0, 1);
    check("accepts", acc_cnt - acc0, nacc);
    check("idx_order", ord_err - ord0, 0);
    check("wait_stable", stab_err - stab0, 0);
    check("done_to_start", gap_err - gap0, 0);
    check("first_start_lat", first_start_cyc - lac, 2);
    check("done_to_frame_done", fd_cyc - last_done_cyc, 1);
  endtask

  initial begin
    int t;
    int lac;
    rst = 1'b1;
    spur_done = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data  = 32'h0;

    tbl[0] = mk(32'h3f800000, 32'h40400000, 32'h40000000, 32'hbf800000, 32'h40400000,
                32'hc0000000, 32'h00000000, 32'hbf800000, 32'hc0800000);
    tbl[1] = mk(32'h40a00000, 32'h40a00000, 32'h40a00000, 32'h40a00000, 32'h40a00000,
                32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000);
    tbl[2] = mk(32'hc0400000, 32'hc0000000, 32'hc0000000, 32'hc0800000, 32'hc0000000,
                32'hbf800000, 32'h00000000, 32'h00000000, 32'hc0000000);
    tbl[3] = mk(32'h3f000000, 32'h3fc00000, 32'h00000001, 32'h3e800000, 32'h3fc00000,
                32'hbf800000, 32'h00000000, 32'hbfc00000, 32'hbfa00000);
    tbl[4] = mk(32'h80000000, 32'h00000000, 32'hbf800000, 32'h80000000, 32'h80000000,
                32'h00000000, 32'h00000000, 32'hbf800000, 32'h00000000);
    tbl[5] = mk(32'h41200000, 32'h40e00000, 32'h3f800000, 32'h41100000, 32'h41200000,
                32'h00000000, 32'hc0400000, 32'hc1100000, 32'hbf800000);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(sif.in_ready), 1);
    check("rst_busy", 32'(sif.busy), 0);
    check("rst_exp_start", 32'(sif.exp_start), 0);
    check("rst_frame_done", 32'(sif.frame_done), 0);
    check("rst_exp_in", sif.exp_in, 0);
    check("rst_max_out", sif.max_out, 0);
    check("rst_exp_idx", 32'(sif.exp_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      lat = 1 + v % 3;
      snap();
      send_frame(v, 0, (v == 1) ? 2 : -1);
      wait_frame();
      @(posedge clk); #1;
      check_frame(v, 4, last_acc_cyc, 1'b1);
    end

    // Long exponent latency, spurious done in ISSUE, input held through DONE
    lat = 20;
    snap();
    send_frame(0, 0, -1);
    sif.in_valid = 1'b1;
    sif.in_data  = tbl[3].din[0];
    t = 0;
    @(negedge clk);
    while (!sif.exp_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("issue_seen", 32'(sif.exp_start), 1);
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (5) @(negedge clk);
    check("spur_issue_idx", 32'(sif.exp_idx), 0);
    check("spur_issue_busy", 32'(sif.busy), 1);
    check("stall_max", sif.max_out, tbl[0].mx);
    #1;
    lac = last_acc_cyc;
    wait_frame();
    @(posedge clk); #1;
    check_frame(0, 5, lac, 1'b0);
    check("b2b_max_first", sif.max_out, tbl[3].din[0]);

    snap();
    send_frame(3, 1, -1);
    wait_frame();
    @(posedge clk); #1;
    check_frame(3, 3, last_acc_cyc, 1'b1);

    // Reset while element 2 is in WAIT
    lat = 20;
    snap();
    send_frame(0, 0, -1);
    t = 0;
    @(negedge clk);
    while (nstart - st0 < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("pre_rst_idx", 32'(sif.exp_idx), 2);
    check("pre_rst_busy", 32'(sif.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(sif.busy), 0);
    check("mid_rst_in_ready", 32'(sif.in_ready), 1);
    check("mid_rst_exp_in", sif.exp_in, 0);
    check("mid_rst_max_out", sif.max_out, 0);
    check("mid_rst_exp_idx", 32'(sif.exp_idx), 0);
    check("mid_rst_exp_start", 32'(sif.exp_start), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    lat = 2;
    snap();
    send_frame(2, 0, -1);
    wait_frame();
    @(posedge clk); #1;
    check_frame(2, 4, last_acc_cyc, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/softmax_max_sub.md
# softmax_max_sub

Front-end stage of the softmax datapath. It buffers one frame of N FP32 scores and tracks their maximum while loading. It then feeds each score-minus-max, one at a time, to the downstream exponent FSM through its start/done handshake. Every value reaching the exponent unit is therefore ≤ 0, which keeps exp() in range.

## Interface
- N, default 8: elements per frame (≥ 2).
- AW, default 3: index width, ≥ clog2(N).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  score on in_data is valid.
- in_ready  out  1  block accepts a score this cycle.
- in_data  in  32  FP32 score.
- exp_in  out  32  FP32 difference to the exponent FSM. Drives its IN_FP32.
- exp_start  out  1  one-cycle start pulse. Drives start_compute.
- exp_done  in  1  exponent FSM seq_done.
- exp_idx  out  AW  index of the element currently at exp_in.
- max_out  out  32  frame maximum, valid from the end of LOAD until the next frame's first accept.
- busy  out  1  high in any state other than LOAD.
- frame_done  out  1  one-cycle pulse after the Nth exponent completes.

## Operation
- **States:** LOAD, SUB, ISSUE, WAIT, DONE.
- **Reset (rst=1):** all registers clear; state=LOAD; wr_idx=0, exp_idx=0; exp_in=0, max_out=0; exp_start=0, frame_done=0, busy=0.
- **LOAD:**
  - in_ready=1. Each in_valid&in_ready stores in_data to buf[wr_idx] and increments wr_idx.
  - First element (wr_idx=0) loads max unconditionally. Later elements replace max if strictly greater.
  - Accepting element N-1 moves to SUB with exp_idx=0.
- **FP32 compare:**
  - Sign-magnitude compare.
  - Any value with exponent field 0 is treated as ±0, and −0 equals +0.
  - NaN/Inf are not handled: undefined.
- **SUB:**
  - exp_in <= buf[exp_idx] − max through a combinational add_sub with max's sign bit inverted.
  - If the result's exponent field is 0, exp_in <= 32'h00000000. This flushes −0 and denormals.
  - Next state is ISSUE.
- **ISSUE:** exp_start=1 for exactly this cycle. Next state is WAIT.
- **WAIT:**
  - exp_start=0; exp_in and exp_idx are held stable.
  - On exp_done=1: if exp_idx==N-1 go to DONE; else increment exp_idx and go to SUB.
- **DONE:**
  - frame_done=1 for one cycle.
  - wr_idx=0, exp_idx=0. Next state is LOAD.
- in_ready=0 in all states except LOAD. Inputs offered outside LOAD are not consumed and the upstream holds them.
- exp_done is sampled only in WAIT; it is ignored in every other state.
- max_out continuously mirrors the max register.

## Timing
- Accept to first exp_start: the Nth accept is at edge k. SUB occupies cycle k+1, and exp_start is high during cycle k+2.
- Per element: SUB(1) + ISSUE(1) + WAIT(≥1, set by the exponent FSM).
- Next element: exp_done sampled high at edge j gives exp_start high during cycle j+2.
- After the last exp_done: frame_done is high the next cycle. in_ready returns one cycle after that.
- Minimum frame period is N load cycles + N·(2+exp latency) + 1.
- rst asserted mid-frame:
  - Immediate return to LOAD; the partial frame is discarded.
  - exp_start deasserts asynchronously.
  - The downstream FSM must be reset by the same rst.
- Back-to-back frames: in_valid may be held high through DONE; the first element of the next frame is accepted on the first LOAD cycle.

## Test plan
- **Basic frame:** N=4, in {3f800000 (1.0), 40400000 (3.0), 40000000 (2.0), bf800000 (−1.0)}.
  - max_out=40400000.
  - exp_in sequence {c0000000, 00000000, bf800000, c0800000} with exp_idx 0..3.
  - One frame_done.
- **All equal:** four × 40a00000. Every exp_in=00000000, never 80000000.
- **Negative max and ties:** {c0400000, c0000000, c0000000, c0800000} → max c0000000; exp_in {bf800000, 0, 0, c0000000}.
- **Handshake stall:** the model delays exp_done 20 cycles per element.
  - exp_start pulses exactly once per element, 1 cycle wide.
  - exp_in stable across each WAIT.
  - in_ready=0 throughout and no extra accepts.
- **Spurious done:** exp_done pulsed during LOAD and ISSUE → no state change and no index advance.
- **Reset mid-frame:** rst asserted during WAIT of element 2.
  - Outputs go to reset values.
  - A fresh 4-element frame then completes correctly with a new max.
